// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format encodings and datapath width shared by imm_gen.
package imm_gen_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } imm_src_e;
endpackage

// File: rtl/imm_gen_decode.sv
// imm_gen_decode: combinational RV32I immediate format mux over instruction bits [31:7].
// IMM_GEN_ZIMM_EN enables the CSR zimm format on encoding 101.
module imm_gen_decode
    import imm_gen_pkg::*;
(
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm
);
    // instr[k] is instruction bit k+7, so instr[24] is the sign bit
    always_comb begin
        imm = '0;
        case (imm_src_e'(imm_src))
            IMM_I:   imm = {{20{instr[24]}}, instr[24:13]};
            IMM_S:   imm = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:   imm = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   imm = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:   imm = {instr[24:5], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_Z:   imm = {27'b0, instr[12:8]};
`endif
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate generator with a registered ID/EX copy and unsupported-format flag.
// IMM_GEN_ZIMM_EN enables the CSR zimm format on ImmSrc 101.
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [24:0]     Instr,
    input  logic [2:0]      ImmSrc,
    input  logic            en,
    input  logic            flush,
    output logic [XLEN-1:0] ImmExt,
    output logic [XLEN-1:0] ImmExtE,
    output logic            ImmSrcErr
);
    imm_gen_decode u_decode (
        .instr   (Instr),
        .imm_src (ImmSrc),
        .imm     (ImmExt)
    );

`ifdef IMM_GEN_ZIMM_EN
    assign ImmSrcErr = ImmSrc > IMM_Z;
`else
    assign ImmSrcErr = ImmSrc > IMM_U;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            ImmExtE <= '0;
        else if (flush)
            ImmExtE <= '0;
        else if (en)
            ImmExtE <= ImmExt;
    end
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed and randomized checks of imm_gen against a field-arithmetic reference model.
// Honours IMM_GEN_ZIMM_EN for the expectation on ImmSrc 101.
module tb_imm_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] Instr = '0;
    logic [2:0]  ImmSrc = '0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] ImmExt, ImmExtE;
    logic        ImmSrcErr;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_e = '0;

    imm_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Instr     (Instr),
        .ImmSrc    (ImmSrc),
        .en        (en),
        .flush     (flush),
        .ImmExt    (ImmExt),
        .ImmExtE   (ImmExtE),
        .ImmSrcErr (ImmSrcErr)
    );

    always #5 clk = ~clk;

    // Rebuild the full instruction word and assemble each immediate from its fields numerically
    function automatic logic [31:0] ref_imm(input logic [24:0] f, input logic [2:0] s, output logic err);
        logic signed [31:0] w;
        logic [31:0] sgn, top;
        w   = {f, 7'b0};
        sgn = w >>> 31;
        err = 1'b0;
        case (s)
            3'd0: begin top = w >>> 20; return top; end
            3'd1: begin top = w >>> 25; return (top << 5) + 32'(w[11:7]); end
            3'd2: return (sgn << 12) + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
            3'd3: return (sgn << 20) + (32'(w[19:12]) << 12) + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
            3'd4: return w & 32'hFFFFF000;
`ifdef IMM_GEN_ZIMM_EN
            3'd5: return 32'(w[19:15]);
`endif
            default: begin err = 1'b1; return 32'd0; end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag, input logic [31:0] exp_imm, input logic exp_err);
        #1;
        chk({tag, "_imm"}, ImmExt, exp_imm);
        chk({tag, "_err"}, {31'b0, ImmSrcErr}, {31'b0, exp_err});
    endtask

    task automatic tick();
        logic e;
        logic [31:0] m;
        m = ref_imm(Instr, ImmSrc, e);
        exp_e = !rst_n ? 32'd0 : flush ? 32'd0 : en ? m : exp_e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        e;
        logic [31:0] m;
        logic [24:0] zf;
        // Reset state
        tick();
        chk("reset", ImmExtE, 32'd0);
        // Directed formats from the test plan
        Instr = 25'(32'hFFF00093 >> 7); ImmSrc = 3'b000;
        chk_comb("i_neg1", 32'hFFFFFFFF, 1'b0);
        Instr = {7'b0, 5'b0, 5'b0, 3'b0, 5'b00100}; ImmSrc = 3'b001;
        chk_comb("s_pos4", 32'd4, 1'b0);
        Instr = 25'h1000000;
        chk_comb("s_neg", 32'hFFFFF800, 1'b0);
        Instr = 25'(32'hFE000EE3 >> 7); ImmSrc = 3'b010;
        chk_comb("b_neg4", 32'hFFFFFFFC, 1'b0);
        Instr = 25'(32'h001000EF >> 7); ImmSrc = 3'b011;
        chk_comb("j_2048", 32'h00000800, 1'b0);
        Instr = 25'(32'h123450B7 >> 7); ImmSrc = 3'b100;
        chk_comb("u_lui", 32'h12345000, 1'b0);
        ImmSrc = 3'b110;
        chk_comb("src110", 32'd0, 1'b1);
        ImmSrc = 3'b111;
        chk_comb("src111", 32'd0, 1'b1);
        zf = 25'h1FFFFFF;
        zf[12:8] = 5'b10101;
        Instr = zf; ImmSrc = 3'b101;
`ifdef IMM_GEN_ZIMM_EN
        chk_comb("zimm", 32'h00000015, 1'b0);
`else
        chk_comb("src101", 32'd0, 1'b1);
`endif
        // Register sequence
        rst_n = 1'b0; en = 1'b1;
        tick();
        chk("reg_reset", ImmExtE, 32'd0);
        rst_n = 1'b1; en = 1'b1; Instr = 25'(32'hFFF00093 >> 7); ImmSrc = 3'b000;
        tick();
        chk("reg_load", ImmExtE, 32'hFFFFFFFF);
        en = 1'b0; Instr = 25'h0001234;
        tick();
        chk("reg_hold", ImmExtE, 32'hFFFFFFFF);
        flush = 1'b1;
        tick();
        chk("reg_flush", ImmExtE, 32'd0);
        flush = 1'b0; en = 1'b1; Instr = 25'h1FFFFFF;
        tick();
        chk("reg_reload", ImmExtE, 32'hFFFFFFFF);
        rst_n = 1'b0; en = 1'b0;
        tick();
        chk("reg_reset_stalled", ImmExtE, 32'd0);
        // Randomized formats and pipeline control
        for (int i = 0; i < 400; i++) begin
            Instr  = 25'($urandom);
            ImmSrc = 3'($urandom_range(0, 7));
            rst_n  = ($urandom_range(0, 15) != 0);
            flush  = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 3) != 0);
            m = ref_imm(Instr, ImmSrc, e);
            chk_comb("rnd_comb", m, e);
            tick();
            chk("rnd_reg", ImmExtE, exp_e);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
